// File: rtl/fetch_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : fetch_ctrl                                                  |
// | Brief    : Instruction fetch sequencer. Owns the fetch PC, issues one  |
// |            outstanding request to instruction memory, applies          |
// |            jalr/jal/branch redirects and buffers returned words in a   |
// |            small FIFO for decode (valid/ready).                        |
// | Options  : FETCH_MISALIGN_TRAP_EN - a misaligned redirect target sets  |
// |            a sticky o_misalign and halts fetch until reset. Without    |
// |            it the low two target bits are silently cleared.            |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          Q_DEPTH  = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_con_b,
  input  logic [31:0] i_addr_b,
  input  logic [1:0]  i_con_j,
  input  logic [31:0] i_addr_j,
  input  logic [31:0] i_addr_jr,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc4,
  output logic [31:0] o_instr,
  input  logic        i_ready,
  output logic        o_flush,
  output logic        o_misalign
);

  localparam int              c_CW    = $clog2(Q_DEPTH + 1);
  localparam logic [c_CW-1:0] c_DEPTH = c_CW'(Q_DEPTH);
  localparam logic [c_CW-1:0] c_ONE   = c_CW'(1);

  localparam logic [1:0] c_ST_REQ   = 2'd0;
  localparam logic [1:0] c_ST_WAIT  = 2'd1;
  localparam logic [1:0] c_ST_DRAIN = 2'd2;
  localparam logic [1:0] c_ST_HALT  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     req_pc_q, req_pc_d;
  logic            flush_q, flush_d;
  logic [c_CW-1:0] count_q, count_d;

  // Entry 0 is always the head, so the decode-facing fields come straight
  // from flops.
  logic [31:0]     fpc_q  [Q_DEPTH];
  logic [31:0]     fpc_d  [Q_DEPTH];
  logic [31:0]     fpc4_q [Q_DEPTH];
  logic [31:0]     fpc4_d [Q_DEPTH];
  logic [31:0]     fins_q [Q_DEPTH];
  logic [31:0]     fins_d [Q_DEPTH];

  logic            w_redir;
  logic            w_active_redir;
  logic            w_bad_tgt;
  logic            w_free;
  logic            w_push;
  logic            w_pop;
  logic            w_clear;
  logic [31:0]     w_tgt_raw;
  logic [31:0]     w_tgt;
  logic [c_CW-1:0] w_wr_idx;

  // Redirect decode: jalr beats jal beats branch; target forced word-aligned.
  always_comb begin
    w_redir = i_con_b | (i_con_j != 2'b00);
    if (i_con_j[1])      w_tgt_raw = i_addr_jr;
    else if (i_con_j[0]) w_tgt_raw = i_addr_j;
    else                 w_tgt_raw = i_addr_b;
    w_tgt = {w_tgt_raw[31:2], 2'b00};
  end

  // Once halted, redirects are no longer applied.
  assign w_active_redir = w_redir & (state_q != c_ST_HALT);

`ifdef FETCH_MISALIGN_TRAP_EN
  logic mis_q;

  assign w_bad_tgt = (w_tgt_raw[1:0] != 2'b00);

  // Sticky trap flag, set by the first misaligned redirect actually taken.
  always_ff @(posedge i_clk) begin
    if (i_rst)                            mis_q <= 1'b0;
    else if (w_active_redir & w_bad_tgt)  mis_q <= 1'b1;
  end

  assign o_misalign = mis_q;
`else
  logic w_unused_tgt_lo;

  assign w_unused_tgt_lo = ^w_tgt_raw[1:0];
  assign w_bad_tgt       = 1'b0;
  assign o_misalign      = 1'b0;
`endif

  // FSM state register together with the PC bookkeeping it owns.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= c_ST_REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      flush_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      flush_q  <= flush_d;
    end
  end

  // FSM next-state: a live redirect overrides the normal state actions.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    flush_d  = 1'b0;
    w_push   = 1'b0;
    w_clear  = 1'b0;
    if (w_active_redir) begin
      pc_d    = w_tgt;
      flush_d = 1'b1;
      w_clear = 1'b1;
      if (w_bad_tgt) begin
        state_d = c_ST_HALT;
      end else if (state_q == c_ST_REQ) begin
        // No request went out this cycle, so nothing is in flight.
        state_d = c_ST_REQ;
      end else begin
        // WAIT or DRAIN: a response arriving now is the wrong-path word and
        // is simply dropped; otherwise wait for it in DRAIN.
        state_d = i_imem_rvalid ? c_ST_REQ : c_ST_DRAIN;
      end
    end else begin
      case (state_q)
        c_ST_REQ: begin
          if (o_imem_req & i_imem_gnt) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + 32'd4;
            state_d  = c_ST_WAIT;
          end
        end
        c_ST_WAIT: begin
          if (i_imem_rvalid) begin
            w_push  = 1'b1;
            state_d = c_ST_REQ;
          end
        end
        c_ST_DRAIN: begin
          if (i_imem_rvalid) state_d = c_ST_REQ;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // FSM outputs. Requests are only made from REQ, where nothing is in
  // flight, so free space reduces to count < depth. Reset holds the
  // request low.
  always_comb begin
    w_free      = (count_q < c_DEPTH);
    o_imem_req  = (state_q == c_ST_REQ) & w_free & ~w_redir & ~i_rst;
    o_imem_addr = pc_q;
    o_valid     = (count_q != '0) & ~w_redir;
    o_flush     = flush_q;
    w_pop       = o_valid & i_ready;
  end

  // FIFO next-state: shift down on pop (keeping the last head when it
  // empties), then write the new word behind the surviving entries.
  always_comb begin
    count_d  = count_q;
    fpc_d    = fpc_q;
    fpc4_d   = fpc4_q;
    fins_d   = fins_q;
    w_wr_idx = count_q;
    if (w_clear) begin
      count_d = '0;
    end else begin
      if (w_pop) begin
        count_d  = count_q - c_ONE;
        w_wr_idx = count_q - c_ONE;
        if (count_q > c_ONE) begin
          for (int i = 0; i < Q_DEPTH - 1; i++) begin
            fpc_d[i]  = fpc_q[i + 1];
            fpc4_d[i] = fpc4_q[i + 1];
            fins_d[i] = fins_q[i + 1];
          end
        end
      end
      if (w_push) begin
        count_d = count_d + c_ONE;
        for (int i = 0; i < Q_DEPTH; i++) begin
          if (c_CW'(i) == w_wr_idx) begin
            fpc_d[i]  = req_pc_q;
            fpc4_d[i] = req_pc_q + 32'd4;
            fins_d[i] = i_imem_rdata;
          end
        end
      end
    end
  end

  // FIFO storage and occupancy.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q <= '0;
      for (int i = 0; i < Q_DEPTH; i++) begin
        fpc_q[i]  <= '0;
        fpc4_q[i] <= '0;
        fins_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      fpc_q   <= fpc_d;
      fpc4_q  <= fpc4_d;
      fins_q  <= fins_d;
    end
  end

  assign o_pc    = fpc_q[0];
  assign o_pc4   = fpc4_q[0];
  assign o_instr = fins_q[0];

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences instruction fetch from a request/grant/response instruction memory with one outstanding request.
- Owns the fetch PC and applies branch, jump and jump-register redirects with fixed priority.
- Buffers returned instructions in a small FIFO and presents them to decode on a valid/ready handshake.
- Sits between the PC-select logic of the fetch stage and the decode pipeline register.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
Q_DEPTH, 2, instruction FIFO entries (>=1, any integer)

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  reset, synchronous, active-high
i_con_b  in  1  taken branch
i_addr_b  in  32  branch target
i_con_j  in  2  00 none, 01 jal, 10 jalr, 11 treated as 10
i_addr_j  in  32  jal target
i_addr_jr  in  32  jalr target
o_imem_req  out  1  fetch request
o_imem_addr  out  32  fetch address
i_imem_gnt  in  1  request accepted this cycle
i_imem_rvalid  in  1  response valid
i_imem_rdata  in  32  instruction word
o_valid  out  1  instruction available to decode
o_pc  out  32  PC of head instruction
o_pc4  out  32  o_pc+4
o_instr  out  32  head instruction
i_ready  in  1  decode accepts head
o_flush  out  1  one-cycle pulse, redirect applied
o_misalign  out  1  sticky misaligned target (feature only, else tied 0)

Behaviour:
- Reset values: o_imem_req=0, o_imem_addr=RESET_PC, o_valid=0, o_pc=0, o_pc4=0, o_instr=0, o_flush=0, o_misalign=0. Reset clears FIFO and state and sets pc_q=RESET_PC. Reset mid-transaction abandons it; any later rvalid is ignored in REQ.
- Redirect: redir = (i_con_j!=0) | i_con_b. Priority is jalr (10/11), then jal (01), then branch. Target[1:0] cleared to 00 (see feature).
- Space: free = (count + outstanding) < Q_DEPTH. A push never overflows.
- States:
  - REQ: o_imem_req = free & ~redir; o_imem_addr = pc_q. On gnt: req_pc<=pc_q, pc_q<=pc_q+4, go to WAIT. rvalid is ignored.
  - WAIT: on rvalid, push {req_pc, req_pc+4, rdata} and go to REQ. Minimum 2 cycles per instruction; gnt and rvalid may arrive in consecutive cycles.
  - DRAIN: a wrong-path request is outstanding. The next rvalid is discarded, then go to REQ. o_imem_req=0.
  - HALT: feature only; no requests until reset.
- On redirect, in any state except HALT:
  - pc_q<=target; FIFO count<=0; o_flush=1 next cycle.
  - WAIT without rvalid: go to DRAIN.
  - WAIT with rvalid the same cycle: discard the response, go to REQ.
  - REQ: no request is issued that cycle (o_imem_req forced 0), so there is no wrong-path grant; stay in REQ.
  - DRAIN: stay in DRAIN with the new pc_q.
- Decode side:
  - o_valid = (count!=0) & ~redir. This is combinational from the redirect inputs; redirect beats pop.
  - Pop when o_valid & i_ready; head fields are registered FIFO outputs.
  - Simultaneous push and pop keeps count unchanged.
  - Empty FIFO: o_valid=0, data holds the last value.
- PC arithmetic: modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.

Optional Feature:
FETCH_MISALIGN_TRAP_EN
- Defined: a redirect whose selected target[1:0]!=00 sets o_misalign (sticky until reset), flushes the FIFO and enters HALT. No further requests are issued; a response still outstanding is discarded.
- Undefined: low two target bits are silently cleared; o_misalign is constant 0; HALT is unreachable.

Test Plan:
- Reset release, gnt=1, rvalid one cycle after each gnt, i_ready=1 -> addresses 0,4,8 requested; o_valid pulses with o_pc 0,4,8, o_pc4 4,8,C, o_instr equal to rdata.
- i_ready=0, Q_DEPTH=2 -> exactly 2 instructions buffered, o_imem_req stays 0. i_ready=1 for one cycle -> one pop, one new request at 8.
- Request at 8 granted, then i_con_b=1 with i_addr_b=0x100 before rvalid -> o_flush pulses, the response for 8 is discarded, next request address is 0x100.
- Same cycle: i_con_j=10, i_addr_jr=0x200, i_con_b=1, i_addr_b=0x300 -> target 0x200; o_valid=0 that cycle even with FIFO non-empty.
- RESET_PC=32'hFFFF_FFFC -> second request address 0x0, o_pc4 of the first instruction is 0x0.
- i_con_j=01, i_addr_j=0x102 -> without macro, next request at 0x100; with FETCH_MISALIGN_TRAP_EN, o_misalign=1, o_imem_req stays 0 until i_rst.
